// File: rtl/square_mover.sv
// Falling-square animator: on each tick erases the square, moves it, and redraws it,
// streaming one pixel per clock to the VGA adapter. Define SQUARE_BOUNCE_EN to bounce instead of wrap.
module square_mover #(
    parameter int unsigned SIZE      = 4,
    parameter int unsigned X_MAX     = 160,
    parameter int unsigned Y_MAX     = 120,
    parameter int unsigned START_X   = 76,
    parameter int unsigned STEP      = 1,
    parameter logic [2:0]  COLOUR    = 3'b100,
    parameter logic [2:0]  BG_COLOUR = 3'b000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick,
    input  logic       go_left,
    input  logic       go_right,
    output logic [7:0] x_out,
    output logic [6:0] y_out,
    output logic [2:0] colour_out,
    output logic       plot,
    output logic       busy,
    output logic       landed
);

    localparam logic [8:0] STEP9    = 9'(STEP);
    localparam logic [8:0] START_X9 = 9'(START_X);
    localparam logic [8:0] X_LIM    = 9'(X_MAX - SIZE);
    localparam logic [8:0] Y_LIM    = 9'(Y_MAX - SIZE);
    localparam logic [2:0] LAST_OFF = 3'(SIZE - 1);

    typedef enum logic [1:0] {
        S_WAIT  = 2'd0,
        S_ERASE = 2'd1,
        S_MOVE  = 2'd2,
        S_DRAW  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        DIR_NONE  = 2'd0,
        DIR_LEFT  = 2'd1,
        DIR_RIGHT = 2'd2
    } dir_t;

    state_t     state_q, state_d;
    dir_t       dir_q, dir_d;
    logic [2:0] ox_q, ox_d;
    logic [2:0] oy_q, oy_d;
    logic [8:0] pos_x_q, pos_x_d;
    logic [8:0] pos_y_q, pos_y_d;
    logic [7:0] x_q, x_d;
    logic [6:0] y_q, y_d;
    logic [2:0] colour_q, colour_d;
    logic       plot_q, plot_d;
    logic       busy_q, busy_d;
    logic       landed_q, landed_d;

    logic [8:0] new_x_s;
    logic [8:0] new_y_s;
    logic       hit_bottom_s;
    logic [8:0] pix_x_s;
    logic [8:0] pix_y_s;

`ifdef SQUARE_BOUNCE_EN
    // 1 = moving up, 0 = moving down
    logic vdir_q, vdir_d;
    logic new_vdir_s;
`endif

    // Next position for the pending move (horizontal step, then fall/bounce)
    always_comb begin
        new_x_s      = pos_x_q;
        new_y_s      = pos_y_q;
        hit_bottom_s = 1'b0;
        case (dir_q)
            DIR_LEFT: begin
                if (pos_x_q >= STEP9) begin
                    new_x_s = pos_x_q - STEP9;
                end else begin
                    new_x_s = 9'd0;
                end
            end
            DIR_RIGHT: begin
                if ((pos_x_q + STEP9) > X_LIM) begin
                    new_x_s = X_LIM;
                end else begin
                    new_x_s = pos_x_q + STEP9;
                end
            end
            default: begin
                new_x_s = pos_x_q;
            end
        endcase
`ifdef SQUARE_BOUNCE_EN
        new_vdir_s = vdir_q;
        if (!vdir_q) begin
            if ((pos_y_q + STEP9) > Y_LIM) begin
                new_y_s      = Y_LIM;
                new_vdir_s   = 1'b1;
                hit_bottom_s = 1'b1;
            end else begin
                new_y_s = pos_y_q + STEP9;
            end
        end else begin
            if (pos_y_q < STEP9) begin
                new_y_s    = 9'd0;
                new_vdir_s = 1'b0;
            end else begin
                new_y_s = pos_y_q - STEP9;
            end
        end
`else
        if ((pos_y_q + STEP9) > Y_LIM) begin
            new_y_s      = 9'd0;
            new_x_s      = START_X9;
            hit_bottom_s = 1'b1;
        end else begin
            new_y_s = pos_y_q + STEP9;
        end
`endif
    end

    assign pix_x_s = pos_x_q + {6'd0, ox_q};
    assign pix_y_s = pos_y_q + {6'd0, oy_q};

    // FSM next state, raster scan counters and registered pixel outputs
    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        ox_d     = ox_q;
        oy_d     = oy_q;
        pos_x_d  = pos_x_q;
        pos_y_d  = pos_y_q;
        x_d      = x_q;
        y_d      = y_q;
        colour_d = colour_q;
        plot_d   = 1'b0;
        busy_d   = (state_q != S_WAIT);
        landed_d = 1'b0;
`ifdef SQUARE_BOUNCE_EN
        vdir_d   = vdir_q;
`endif
        case (state_q)
            S_WAIT: begin
                if (tick) begin
                    if (go_left && !go_right) begin
                        dir_d = DIR_LEFT;
                    end else if (go_right && !go_left) begin
                        dir_d = DIR_RIGHT;
                    end else begin
                        dir_d = DIR_NONE;
                    end
                    ox_d    = 3'd0;
                    oy_d    = 3'd0;
                    state_d = S_ERASE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_ERASE, S_DRAW: begin
                plot_d   = 1'b1;
                x_d      = 8'(pix_x_s);
                y_d      = 7'(pix_y_s);
                colour_d = (state_q == S_ERASE) ? BG_COLOUR : COLOUR;
                if (ox_q == LAST_OFF) begin
                    ox_d = 3'd0;
                    if (oy_q == LAST_OFF) begin
                        oy_d    = 3'd0;
                        state_d = (state_q == S_ERASE) ? S_MOVE : S_WAIT;
                    end else begin
                        oy_d = oy_q + 3'd1;
                    end
                end else begin
                    ox_d = ox_q + 3'd1;
                end
            end
            S_MOVE: begin
                pos_x_d  = new_x_s;
                pos_y_d  = new_y_s;
                landed_d = hit_bottom_s;
`ifdef SQUARE_BOUNCE_EN
                vdir_d   = new_vdir_s;
`endif
                state_d  = S_DRAW;
            end
            default: begin
                state_d = S_WAIT;
            end
        endcase
    end

    // State and output registers; reset aborts any scan and queues the initial paint
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= S_DRAW;
            dir_q    <= DIR_NONE;
            ox_q     <= 3'd0;
            oy_q     <= 3'd0;
            pos_x_q  <= START_X9;
            pos_y_q  <= 9'd0;
            x_q      <= 8'd0;
            y_q      <= 7'd0;
            colour_q <= 3'd0;
            plot_q   <= 1'b0;
            busy_q   <= 1'b1;
            landed_q <= 1'b0;
`ifdef SQUARE_BOUNCE_EN
            vdir_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            ox_q     <= ox_d;
            oy_q     <= oy_d;
            pos_x_q  <= pos_x_d;
            pos_y_q  <= pos_y_d;
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
            plot_q   <= plot_d;
            busy_q   <= busy_d;
            landed_q <= landed_d;
`ifdef SQUARE_BOUNCE_EN
            vdir_q   <= vdir_d;
`endif
        end
    end

    assign x_out      = x_q;
    assign y_out      = y_q;
    assign colour_out = colour_q;
    assign plot       = plot_q;
    assign busy       = busy_q;
    assign landed     = landed_q;

endmodule

// File: tb/tb_square_mover.sv
// Table-driven bench for square_mover: each record gives a tick count, buttons and the
// hand-computed erase/draw corners and landed value of the final tick.
module tb_square_mover;

    logic       clock    = 1'b0;
    logic       reset    = 1'b0;
    logic       tick     = 1'b0;
    logic       go_left  = 1'b0;
    logic       go_right = 1'b0;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic [2:0] colour_out;
    logic       plot;
    logic       busy;
    logic       landed;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic l;
        logic r;
        int   reps;
        int   ox;
        int   oy;
        int   nx;
        int   ny;
        logic lnd;
        logic retick;
    } vec_t;

    vec_t vecs[$];

    square_mover dut (
        .clock      (clock),
        .reset      (reset),
        .tick       (tick),
        .go_left    (go_left),
        .go_right   (go_right),
        .x_out      (x_out),
        .y_out      (y_out),
        .colour_out (colour_out),
        .plot       (plot),
        .busy       (busy),
        .landed     (landed)
    );

    always #10 clock = ~clock;

    function automatic logic [20:0] obs();
        return {plot, busy, landed, x_out, y_out, colour_out};
    endfunction

    function automatic logic [20:0] ctl();
        return {plot, busy, landed, 18'd0};
    endfunction

    function automatic logic [20:0] pix(int x, int y, logic [2:0] c);
        return {1'b1, 1'b1, 1'b0, 8'(x), 7'(y), c};
    endfunction

    task automatic check(string name, logic [20:0] act, logic [20:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got plot/busy/landed=%b x=%0d y=%0d c=%b, expected plot/busy/landed=%b x=%0d y=%0d c=%b",
                     name, act[20:18], act[17:10], act[9:3], act[2:0],
                     exp[20:18], exp[17:10], exp[9:3], exp[2:0]);
        end
    endtask

    // 16 pixels of the post-reset paint at (76,0), then idle
    task automatic check_init(string tag);
        for (int i = 0; i < 16; i++) begin
            @(negedge clock);
            check($sformatf("%s_px%0d", tag, i), obs(), pix(76 + i % 4, i / 4, 3'b100));
        end
        @(negedge clock);
        check($sformatf("%s_idle", tag), ctl(), 21'd0);
    endtask

    task automatic run_vec(int idx, vec_t v);
        for (int t = 0; t < v.reps; t++) begin
            bit last;
            last = (t == v.reps - 1);
            @(negedge clock);
            go_left  = v.l;
            go_right = v.r;
            tick     = 1'b1;
            @(negedge clock);
            tick = 1'b0;
            for (int i = 0; i < 35; i++) begin
                logic [20:0] exp;
                @(negedge clock);
                tick = (v.retick && last && i == 4) ? 1'b1 : 1'b0;
                if (i < 16) begin
                    exp = pix(v.ox + i % 4, v.oy + i / 4, 3'b000);
                end else if (i == 16) begin
                    exp = {1'b0, 1'b1, v.lnd, 18'd0};
                end else if (i < 33) begin
                    exp = pix(v.nx + (i - 17) % 4, v.ny + (i - 17) / 4, 3'b100);
                end else begin
                    exp = 21'd0;
                end
                if (last) begin
                    if (i == 16 || i >= 33) begin
                        check($sformatf("vec%0d_cyc%0d", idx, i), ctl(), exp);
                    end else begin
                        check($sformatf("vec%0d_cyc%0d", idx, i), obs(), exp);
                    end
                end
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        repeat (2) @(negedge clock);
        check("reset_state", obs(), {1'b0, 1'b1, 1'b0, 18'd0});
        reset = 1'b1;
        check_init("init");

        //                 l     r     reps ox   oy   nx   ny   lnd   retick
        vecs.push_back('{1'b0, 1'b0, 1,   76,  0,   76,  1,   1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 1,   76,  1,   77,  2,   1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 77,  1,   78,  0,   79,  1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 1,   0,   79,  0,   80,  1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1,   0,   80,  0,   81,  1'b0, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 35,  0,   115, 0,   116, 1'b0, 1'b0});
`ifdef SQUARE_BOUNCE_EN
        vecs.push_back('{1'b0, 1'b0, 1,   0,   116, 0,   116, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1,   0,   116, 0,   115, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1,   0,   115, 0,   114, 1'b0, 1'b0});
`else
        vecs.push_back('{1'b0, 1'b0, 1,   0,   116, 76,  0,   1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 80,  155, 79,  156, 80,  1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 1,   156, 80,  156, 81,  1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 1,   156, 81,  156, 82,  1'b0, 1'b0});
`endif
        foreach (vecs[k]) begin
            run_vec(k, vecs[k]);
        end

        // reset at the 8th erase pixel aborts the scan; initial paint follows release
        go_left  = 1'b0;
        go_right = 1'b0;
        @(negedge clock);
        tick = 1'b1;
        @(negedge clock);
        tick = 1'b0;
        repeat (8) @(negedge clock);
        check("mid_erase_px8", ctl(), {1'b1, 1'b1, 1'b0, 18'd0});
        reset = 1'b0;
        @(negedge clock);
        check("mid_reset", obs(), {1'b0, 1'b1, 1'b0, 18'd0});
        @(negedge clock);
        reset = 1'b1;
        check_init("post");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
